// File: rtl/candle_pkg.sv
// Shared constants and types for the candle sequencer: geometry, op codes, FSM states.
package candle_pkg;

   localparam int unsigned NUM_CANDLES = 8;
   localparam int unsigned POS_W       = 3;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_LIGHT = 2'b01;
   localparam logic [1:0] OP_SNUFF = 2'b10;

   localparam logic [POS_W:0]   MAX_COUNT = (POS_W + 1)'(NUM_CANDLES);
   localparam logic [POS_W-1:0] TOP_POS   = POS_W'(NUM_CANDLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRunSet,
      StRunClr,
      StFinish
   } state_e;

   // Requests beyond the number of candles act on every candle.
   function automatic logic [POS_W:0] sat_count(input logic [POS_W:0] count);
      return (count > MAX_COUNT) ? MAX_COUNT : count;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running prescaler: one-cycle tick every STEP_CYCLES clocks, restartable so that
// the first tick lands STEP_CYCLES cycles after the restart edge.
module step_timer #(
   parameter int unsigned STEP_CYCLES = 4
) (
   input  logic sys_clk,
   input  logic clr,
   input  logic restart,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(STEP_CYCLES - 1);

   logic [7:0] cnt_q;

   always_ff @(posedge sys_clk) begin
      if (clr || restart) begin
         cnt_q <= 8'd0;
      end else if (cnt_q == LAST) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/candle_sequencer.sv
// Command-driven scheduler for the candle state register's set/clear strobes:
// lights upward from 0 or snuffs downward from the top, one candle per step.
module candle_sequencer
   import candle_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 4
) (
   input  logic             sys_clk,
   input  logic             clr,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [POS_W:0]   cmd_count,
   output logic             cmd_ready,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [POS_W-1:0] pos_to_set,
   output logic             set_enable,
   output logic [POS_W-1:0] pos_to_clear,
   output logic             clear_enable
);

   state_e           state_q, state_d;
   logic [POS_W-1:0] idx_q, idx_d;
   // Strobes still to issue after the one currently on the outputs.
   logic [POS_W:0]   left_q, left_d;
   logic [POS_W:0]   n_sat;
   logic             restart, tick;
   logic             set_en_d, clr_en_d, done_d, aborted_d, busy_d, ready_d;
   logic [POS_W-1:0] pos_set_d, pos_clr_d;

   step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_step_timer (
      .sys_clk(sys_clk),
      .clr    (clr),
      .restart(restart),
      .tick   (tick)
   );

   assign n_sat = sat_count(cmd_count);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      left_d    = left_q;
      set_en_d  = 1'b0;
      clr_en_d  = 1'b0;
      pos_set_d = '0;
      pos_clr_d = '0;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      restart   = 1'b0;

      unique case (state_q)
         StIdle: begin
            idx_d = '0;
            if (cmd_valid) begin
               restart = 1'b1;
               if (cmd_op == OP_LIGHT && n_sat != '0) begin
                  state_d   = StRunSet;
                  idx_d     = '0;
                  left_d    = n_sat - (POS_W + 1)'(1);
                  set_en_d  = 1'b1;
                  pos_set_d = '0;
               end else if (cmd_op == OP_SNUFF && n_sat != '0) begin
                  state_d   = StRunClr;
                  idx_d     = TOP_POS;
                  left_d    = n_sat - (POS_W + 1)'(1);
                  clr_en_d  = 1'b1;
                  pos_clr_d = TOP_POS;
               end else begin
                  state_d = StFinish;
                  done_d  = 1'b1;
               end
            end
         end
         StRunSet: begin
            if (abort) begin
               state_d   = StFinish;
               aborted_d = 1'b1;
            end else if (set_enable && left_q == '0) begin
               state_d = StFinish;
               done_d  = 1'b1;
            end else if (tick) begin
               idx_d     = idx_q + POS_W'(1);
               left_d    = left_q - (POS_W + 1)'(1);
               set_en_d  = 1'b1;
               pos_set_d = idx_q + POS_W'(1);
            end
         end
         StRunClr: begin
            if (abort) begin
               state_d   = StFinish;
               aborted_d = 1'b1;
            end else if (clear_enable && left_q == '0) begin
               state_d = StFinish;
               done_d  = 1'b1;
            end else if (tick) begin
               idx_d     = idx_q - POS_W'(1);
               left_d    = left_q - (POS_W + 1)'(1);
               clr_en_d  = 1'b1;
               pos_clr_d = idx_q - POS_W'(1);
            end
         end
         StFinish: begin
            state_d = StIdle;
            idx_d   = '0;
            left_d  = '0;
         end
      endcase

      busy_d  = (state_d != StIdle);
      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge sys_clk) begin
      if (clr) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         left_q       <= '0;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         set_enable   <= 1'b0;
         pos_to_set   <= '0;
         clear_enable <= 1'b0;
         pos_to_clear <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         left_q       <= left_d;
         cmd_ready    <= ready_d;
         busy         <= busy_d;
         done         <= done_d;
         aborted      <= aborted_d;
         set_enable   <= set_en_d;
         pos_to_set   <= pos_set_d;
         clear_enable <= clr_en_d;
         pos_to_clear <= pos_clr_d;
      end
   end

endmodule

// File: tb/tb_candle_sequencer.sv
// Scoreboard bench: two sequencers (step 4 and step 1) against a timeline model of
// expected strobe/done/aborted events and busy windows.
module tb_candle_sequencer;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic       clr          [2];
   logic       cmd_valid    [2];
   logic [1:0] cmd_op       [2];
   logic [3:0] cmd_count    [2];
   logic       abort        [2];
   logic       cmd_ready    [2];
   logic       busy         [2];
   logic       done         [2];
   logic       aborted      [2];
   logic [2:0] pos_to_set   [2];
   logic       set_enable   [2];
   logic [2:0] pos_to_clear [2];
   logic       clear_enable [2];

   candle_sequencer #(.STEP_CYCLES(4)) dut0 (
      .sys_clk(sys_clk), .clr(clr[0]), .cmd_valid(cmd_valid[0]), .cmd_op(cmd_op[0]),
      .cmd_count(cmd_count[0]), .cmd_ready(cmd_ready[0]), .abort(abort[0]), .busy(busy[0]),
      .done(done[0]), .aborted(aborted[0]), .pos_to_set(pos_to_set[0]),
      .set_enable(set_enable[0]), .pos_to_clear(pos_to_clear[0]),
      .clear_enable(clear_enable[0])
   );

   candle_sequencer #(.STEP_CYCLES(1)) dut1 (
      .sys_clk(sys_clk), .clr(clr[1]), .cmd_valid(cmd_valid[1]), .cmd_op(cmd_op[1]),
      .cmd_count(cmd_count[1]), .cmd_ready(cmd_ready[1]), .abort(abort[1]), .busy(busy[1]),
      .done(done[1]), .aborted(aborted[1]), .pos_to_set(pos_to_set[1]),
      .set_enable(set_enable[1]), .pos_to_clear(pos_to_clear[1]),
      .clear_enable(clear_enable[1])
   );

   // Event masks: 1 set strobe, 2 clear strobe, 4 done, 8 aborted.
   typedef struct {
      int t;
      int mask;
      int pos;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];
   int  bs[2];
   int  be[2];
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;
   bit  mon_en = 1'b0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic int step_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic bit peek(input int d, output ev_t e);
      e = '{t: 0, mask: 0, pos: 0};
      if (d == 0) begin
         if (q0.size() == 0) return 1'b0;
         e = q0[0];
      end else begin
         if (q1.size() == 0) return 1'b0;
         e = q1[0];
      end
      return 1'b1;
   endfunction

   task automatic drop(input int d);
      ev_t e;
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
   endtask

   task automatic push_ev(input int d, input int t, input int mask, input int pos);
      ev_t e;
      e = '{t: t, mask: mask, pos: pos};
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic check_cycle(input int d);
      int  mask, pos;
      bit  exp_busy, have;
      ev_t e;
      mask = (set_enable[d] === 1'b1 ? 1 : 0) | (clear_enable[d] === 1'b1 ? 2 : 0) |
             (done[d] === 1'b1 ? 4 : 0) | (aborted[d] === 1'b1 ? 8 : 0);
      pos  = (set_enable[d] === 1'b1) ? int'(pos_to_set[d]) :
             (clear_enable[d] === 1'b1) ? int'(pos_to_clear[d]) : 0;
      exp_busy = (cyc >= bs[d]) && (cyc <= be[d]);
      checks++;
      if (busy[d] !== exp_busy || cmd_ready[d] !== !exp_busy ||
          (set_enable[d] !== 1'b1 && pos_to_set[d] !== 3'd0) ||
          (clear_enable[d] !== 1'b1 && pos_to_clear[d] !== 3'd0)) begin
         errors++;
         $display("FAIL status dut%0d cyc=%0d: busy=%b ready=%b pset=%0d pclr=%0d, required busy=%b ready=%b idle pos 0",
                  d, cyc, busy[d], cmd_ready[d], pos_to_set[d], pos_to_clear[d],
                  exp_busy, !exp_busy);
      end
      forever begin
         have = peek(d, e);
         if (!have || e.t >= cyc) break;
         checks++;
         errors++;
         $display("FAIL missed_event dut%0d cyc=%0d: got nothing, required mask=%0d pos=%0d at cyc %0d",
                  d, cyc, e.mask, e.pos, e.t);
         drop(d);
      end
      if (mask != 0) begin
         checks++;
         have = peek(d, e);
         if (!have || e.t != cyc) begin
            errors++;
            $display("FAIL unexpected_event dut%0d cyc=%0d: got mask=%0d pos=%0d, required none",
                     d, cyc, mask, pos);
         end else begin
            drop(d);
            if (mask != e.mask || pos != e.pos) begin
               errors++;
               $display("FAIL event dut%0d cyc=%0d: got mask=%0d pos=%0d, required mask=%0d pos=%0d",
                        d, cyc, mask, pos, e.mask, e.pos);
            end
         end
      end
   endtask

   always @(negedge sys_clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) check_cycle(d);
      end
   end

   // Issue one command; ab_off/clr_off place an abort/reset edge relative to acceptance.
   task automatic run_cmd(input int d, input logic [1:0] op, input int cnt, input int ab_off,
                          input int clr_off);
      int a, n, s, last, fin_t, endt, b, r, tries, c, t;
      bit run_op, aborting, resetting;
      s     = step_of(d);
      tries = 0;
      @(negedge sys_clk);
      abort[d] = 1'b0;
      while (cmd_ready[d] !== 1'b1) begin
         if (tries >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut%0d: cmd_ready=%b, required 1", d, cmd_ready[d]);
            return;
         end
         tries++;
         @(negedge sys_clk);
      end
      a      = cyc + 1;
      n      = (cnt > 8) ? 8 : cnt;
      run_op = (op == 2'b01 || op == 2'b10) && n > 0;
      last   = run_op ? a + (n - 1) * s : a - 1;
      b      = a + ab_off;
      aborting = (ab_off > 0) && run_op && (b - 1 <= last);
      fin_t  = aborting ? b : (run_op ? last + 1 : a);
      r      = a + clr_off;
      resetting = (clr_off > 0) && (r <= fin_t);
      endt   = resetting ? r - 1 : fin_t;
      if (run_op) begin
         for (int i = 0; i < n; i++) begin
            t = a + i * s;
            if (!(aborting && t >= b) && !(resetting && t >= r))
               push_ev(d, t, (op == 2'b01) ? 1 : 2, (op == 2'b01) ? i : 7 - i);
         end
      end
      if (!resetting) push_ev(d, fin_t, aborting ? 8 : 4, 0);
      bs[d] = a;
      be[d] = endt;

      cmd_valid[d] = 1'b1;
      cmd_op[d]    = op;
      cmd_count[d] = 4'(cnt);
      forever begin
         @(negedge sys_clk);
         c = cyc;
         // Junk commands while busy must be ignored.
         cmd_valid[d] = (c < endt) ? 1'($urandom % 2) : 1'b0;
         cmd_op[d]    = 2'($urandom);
         cmd_count[d] = 4'($urandom);
         abort[d]     = (ab_off > 0) && (c + 1 == b);
         clr[d]       = (clr_off > 0) && (c + 1 == r);
         if (c >= endt) break;
      end
      @(negedge sys_clk);
      cmd_valid[d] = 1'b0;
      cmd_op[d]    = 2'b00;
      cmd_count[d] = 4'd0;
      abort[d]     = 1'b0;
      clr[d]       = 1'b0;
   endtask

   // Idle gap with abort toggling, which must be ignored.
   task automatic idle(input int d, input int k);
      repeat (k) begin
         @(negedge sys_clk);
         abort[d] = 1'($urandom % 2);
      end
   endtask

   task automatic random_ops(input int d, input int num);
      int op, cnt, ab_off, clr_off, s;
      s = step_of(d);
      for (int i = 0; i < num; i++) begin
         op      = int'($urandom % 4);
         cnt     = int'($urandom % 16);
         ab_off  = ($urandom % 4 == 0) ? 1 + int'($urandom % (s * 8 + 2)) : 0;
         clr_off = ($urandom % 8 == 0) ? 1 + int'($urandom % 20) : 0;
         if (clr_off > 0) ab_off = 0;
         run_cmd(d, 2'(op), cnt, ab_off, clr_off);
         idle(d, int'($urandom % 3));
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         clr[d]       = 1'b1;
         cmd_valid[d] = 1'b0;
         cmd_op[d]    = 2'b00;
         cmd_count[d] = 4'd0;
         abort[d]     = 1'b0;
         bs[d]        = 1;
         be[d]        = 0;
      end
      repeat (3) @(negedge sys_clk);
      clr[0] = 1'b0;
      clr[1] = 1'b0;
      mon_en = 1'b1;
      idle(0, 3);

      run_cmd(0, 2'b01, 8, 0, 0);
      run_cmd(0, 2'b10, 3, 0, 0);
      run_cmd(0, 2'b01, 12, 0, 0);
      run_cmd(0, 2'b01, 0, 0, 0);
      run_cmd(0, 2'b00, 5, 0, 0);
      run_cmd(0, 2'b11, 5, 0, 0);
      run_cmd(0, 2'b01, 8, 9, 0);
      run_cmd(0, 2'b10, 8, 0, 6);
      run_cmd(0, 2'b10, 2, 1, 0);
      run_cmd(0, 2'b01, 2, 6, 0);
      random_ops(0, 25);

      run_cmd(1, 2'b01, 4, 0, 0);
      run_cmd(1, 2'b10, 8, 3, 0);
      run_cmd(1, 2'b10, 15, 0, 0);
      run_cmd(1, 2'b01, 8, 0, 4);
      random_ops(1, 20);

      repeat (10) @(negedge sys_clk);
      checks++;
      if (q0.size() != 0) begin
         errors++;
         $display("FAIL leftover dut0: %0d events pending, required 0", q0.size());
      end
      checks++;
      if (q1.size() != 0) begin
         errors++;
         $display("FAIL leftover dut1: %0d events pending, required 0", q1.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/candle_sequencer.md
Name: candle_sequencer

Overview:
- Command-driven scheduler that sequences the set/clear strobe interface of the 8-candle state register.
- Lights candles upward from position 0, or extinguishes them downward from the top, one candle per STEP_CYCLES clocks.
- Host side uses a valid/ready command handshake and receives busy/done/aborted status.
- Sits between the control/host logic and the candle state register; it is the only driver of that register's set/clear ports.

Parameters:
- NUM_CANDLES, 8, number of candle positions; positions are 0..NUM_CANDLES-1.
- STEP_CYCLES, 4, clocks between successive strobes; legal range is 1..255.
- POS_W, 3, position width; equals clog2(NUM_CANDLES).

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- clr  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_op  input  2  operation: 00 NOP, 01 LIGHT, 10 SNUFF, 11 reserved (treated as NOP).
- cmd_count  input  POS_W+1  number of candles to act on.
- cmd_ready  output  1  block can accept a command.
- abort  input  1  cancel the current operation.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: operation completed normally.
- aborted  output  1  one-cycle pulse: operation cancelled.
- pos_to_set  output  POS_W  candle index to light.
- set_enable  output  1  one-cycle set strobe.
- pos_to_clear  output  POS_W  candle index to extinguish.
- clear_enable  output  1  one-cycle clear strobe.

Behaviour:
- Reset (clr high at an edge):
  - Next cycle: state IDLE, index and step counter 0.
  - All outputs 0 except cmd_ready=1.
  - Reset mid-operation drops the operation with no done or aborted pulse.
- States: IDLE, RUN_SET, RUN_CLR, FINISH.
- IDLE:
  - cmd_ready=1, busy=0.
  - Accept on cmd_valid && cmd_ready at edge k.
  - Latched count n = min(cmd_count, NUM_CANDLES).
- LIGHT:
  - n=0: go to FINISH.
  - Otherwise go to RUN_SET with idx=0.
  - set_enable=1 and pos_to_set=0 in cycle k+1.
  - Each following strobe is exactly STEP_CYCLES cycles after the previous one; idx increments by 1.
  - After the n-th strobe, go to FINISH.
- SNUFF:
  - n=0: go to FINISH.
  - Otherwise go to RUN_CLR with idx=NUM_CANDLES-1.
  - clear_enable=1 and pos_to_clear=NUM_CANDLES-1 in cycle k+1.
  - idx decrements by 1 per strobe at the same spacing; after n strobes, go to FINISH.
- NUP or reserved op: go directly to FINISH.
- FINISH: lasts one cycle with done=1, then IDLE. The done cycle is the cycle after the last strobe, or k+1 if there were no strobes.
- busy=1 in RUN_SET, RUN_CLR and FINISH; cmd_ready=0 in those states.
- Strobe outputs:
  - Strobes last exactly one cycle.
  - set_enable and clear_enable are never high together.
  - pos_to_set and pos_to_clear are 0 whenever their enable is low.
- Abort:
  - abort high in RUN_SET or RUN_CLR at an edge: no further strobes.
  - aborted=1 for the next cycle, with no done pulse, then IDLE.
  - If abort coincides with a strobe cycle, that strobe is still issued (registered output already high), but it is the last.
  - abort is ignored in IDLE and FINISH.
- cmd_valid while busy is ignored; the host must hold it until cmd_ready.
- Counter widths:
  - Step counter counts 0..STEP_CYCLES-1 and wraps.
  - idx never wraps: LIGHT stops at NUM_CANDLES-1, SNUFF stops at 0.
- STEP_CYCLES=1: back-to-back strobes in consecutive cycles.
- All outputs are registered.

Decomposition:
- Package candle_pkg holds:
  - NUM_CANDLES, POS_W
  - op-code constants OP_NOP, OP_LIGHT, OP_SNUFF
  - state encoding constants
- Sub-module step_timer: free prescaler with start/clear input.
  - Emits a one-cycle tick every STEP_CYCLES clocks.
  - Restarted on command acceptance so the first strobe lands at k+1.

Test Plan:
- Reset then LIGHT with count=8, STEP_CYCLES=4, accepted at cycle 10 -> set_enable in cycles 11,15,...,39 with pos 0..7; done at 40; cmd_ready back at 41.
- SNUFF with count=3, STEP_CYCLES=4, accepted at cycle 5 -> clear_enable at 6,10,14 with pos 7,6,5; done at 15; set_enable stays 0 throughout.
- LIGHT with count=12 -> saturates to 8 strobes (pos 0..7); LIGHT with count=0 -> no strobes, done at k+1.
- LIGHT with count=8, abort asserted at the edge following the strobe for pos 2 -> no strobe for pos 3; aborted=1 for one cycle; done never asserted; IDLE after.
- clr asserted mid-SNUFF -> next cycle all strobes 0, busy=0, cmd_ready=1; no done or aborted pulse. Also cmd_valid pulses while busy -> ignored.
- STEP_CYCLES=1, LIGHT count=4 -> set_enable high for 4 consecutive cycles with pos 0,1,2,3; done the next cycle.
